// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV multiply stage and its result collector.
// Sizes, collector state encoding and a signed-overflow helper.
package spmv_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 64;
  localparam int NUM_ROWS = 1024;

  typedef enum logic [2:0] {
    CLEAR,
    ACCUM,
    FLUSH,
    READOUT,
    DONE
  } state_t;

  // Two's-complement add overflows when both operands share a sign the sum lacks.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                   input logic sign_sum);
    return (sign_a == sign_b) && (sign_sum != sign_a);
  endfunction

endpackage

// File: rtl/spmv_result_ram.sv
// Result vector storage: one write port, one synchronous read port.
// Read data changes only when re is high, so it doubles as a holding register.
module spmv_result_ram #(
  parameter int ADDR_W   = spmv_pkg::ADDR_W,
  parameter int DATA_W   = spmv_pkg::DATA_W,
  parameter int NUM_ROWS = spmv_pkg::NUM_ROWS
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_ROWS];

  // NOTE: the array has no reset so it maps onto block RAM; the collector
  // zeroes it explicitly with its CLEAR sweep instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spmv_result_collector.sv
// Sums per-row product beats into a result RAM, then streams rows 0..max_row
// out over valid/ready once the multiplier reports done.
module spmv_result_collector #(
  parameter int ADDR_W   = spmv_pkg::ADDR_W,
  parameter int DATA_W   = spmv_pkg::DATA_W,
  parameter int NUM_ROWS = spmv_pkg::NUM_ROWS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_zeros,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic              mul_done,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_row,
  output logic              out_last,
  output logic              out_done,
  output logic              err,
  output logic              ovf
);

  import spmv_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt, cur_row, max_row, rd_ptr;
  logic [DATA_W-1:0] acc;
  logic              row_open, any_row;

  logic              accept, drop, same_row, pair_ovf, acc_ovf;
  logic [DATA_W-1:0] pair_sum, term, acc_sum, rd_data;
  logic              we, re;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign accept   = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign same_row = !row_open || (in_addr == cur_row);
  assign pair_sum = in_op1 + in_op2;
  assign term     = in_zeros ? '0 : pair_sum;
  assign acc_sum  = acc + term;
  assign pair_ovf = !in_zeros &&
                    add_ovf(in_op1[DATA_W-1], in_op2[DATA_W-1], pair_sum[DATA_W-1]);
  assign acc_ovf  = same_row &&
                    add_ovf(acc[DATA_W-1], term[DATA_W-1], acc_sum[DATA_W-1]);

  // Fetch the next row when the output slot is empty or being drained, but
  // never past the last row.
  assign re       = (state == READOUT) && (!out_valid || (out_ready && !out_last));
  assign out_data = out_valid ? rd_data : '0;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    we    = 1'b0;
    waddr = cur_row;
    wdata = acc;
    unique case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        wdata = '0;
      end
      ACCUM:   we = accept && !same_row;
      FLUSH:   we = row_open;
      default: we = 1'b0;
    endcase
  end

  spmv_result_ram #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_ROWS(NUM_ROWS)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      acc       <= '0;
      cur_row   <= '0;
      row_open  <= 1'b0;
      max_row   <= '0;
      any_row   <= 1'b0;
      rd_ptr    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
      out_done  <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (drop) err <= 1'b1;
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ROW) begin
            state    <= ACCUM;
            in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (same_row) begin
              acc <= acc_sum;
            end else begin
              acc <= term;
              if (in_addr < cur_row) err <= 1'b1;
            end
            cur_row  <= in_addr;
            row_open <= 1'b1;
            any_row  <= 1'b1;
            if (in_addr > max_row) max_row <= in_addr;
            if (pair_ovf || acc_ovf) ovf <= 1'b1;
          end
          if (mul_done) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          rd_ptr <= '0;
          if (any_row) begin
            state <= READOUT;
          end else begin
            state    <= DONE;
            out_done <= 1'b1;
          end
        end
        READOUT: begin
          if (re) begin
            out_valid <= 1'b1;
            out_row   <= rd_ptr;
            out_last  <= (rd_ptr == max_row);
            rd_ptr    <= rd_ptr + 1'b1;
          end else if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_done  <= 1'b1;
            state     <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
